// File: rtl/line_pkg.sv
// Shared definitions for the line setup stage: coordinate/colour widths,
// screen limits and the setup state encoding.
package line_pkg;

  localparam int COORD_W      = 9;
  localparam int SCREEN_MAX_X = 319;
  localparam int SCREEN_MAX_Y = 239;
  localparam int COLOR_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_SWAPXY,
    ST_ORDER,
    ST_START,
    ST_RELEASE
  } line_setup_state_t;

endpackage

// File: rtl/abs_diff.sv
// Unsigned absolute difference |a-b|, computed as max-min so it never wraps.
module abs_diff #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Subtract the smaller operand from the larger one
  always_comb begin
    y = (a > b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/line_setup.sv
// line_setup: normalises a raw line request for the Bresenham drawer.
// The line is made shallow (x/y swap, flagged by steep) and its endpoints
// ordered so realx0 <= realx1; stt is then held for the whole draw and
// released on draw_done.
// Optional build macro LINE_SETUP_CLIP_EN: clamp captured coordinates to
// MAX_X / MAX_Y before the difference step.
module line_setup
  import line_pkg::*;
#(
  parameter int WIDTH = COORD_W,
  parameter int MAX_X = SCREEN_MAX_X,
  parameter int MAX_Y = SCREEN_MAX_Y
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x0,
  input  logic [WIDTH-1:0]   in_y0,
  input  logic [WIDTH-1:0]   in_x1,
  input  logic [WIDTH-1:0]   in_y1,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               draw_done,
  output logic               stt,
  output logic               steep,
  output logic [WIDTH-1:0]   realx0,
  output logic [WIDTH-1:0]   realy0,
  output logic [WIDTH-1:0]   realx1,
  output logic [WIDTH-1:0]   realy1,
  output logic [COLOR_W-1:0] color_out,
  output logic               busy
);

`ifdef LINE_SETUP_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] LIM_X = WIDTH'(MAX_X);
  localparam logic [WIDTH-1:0] LIM_Y = WIDTH'(MAX_Y);

  line_setup_state_t state_reg, state_next;

  // working copy of the request
  logic [WIDTH-1:0]   x0_reg, y0_reg, x1_reg, y1_reg;
  logic [COLOR_W-1:0] color_reg;
  logic [WIDTH-1:0]   adx_reg, ady_reg;
  logic               steep_work_reg;

  // published results
  logic [WIDTH-1:0]   realx0_reg, realy0_reg, realx1_reg, realy1_reg;
  logic [COLOR_W-1:0] color_out_reg;
  logic               steep_reg;
  logic               stt_reg;

  logic [WIDTH-1:0] cap_x0, cap_y0, cap_x1, cap_y1;
  logic [WIDTH-1:0] adx, ady;

  // Capture-time clamping; folds away to a pass-through when clipping is off
  always_comb begin
    cap_x0 = (CLIP_EN && (in_x0 > LIM_X)) ? LIM_X : in_x0;
    cap_y0 = (CLIP_EN && (in_y0 > LIM_Y)) ? LIM_Y : in_y0;
    cap_x1 = (CLIP_EN && (in_x1 > LIM_X)) ? LIM_X : in_x1;
    cap_y1 = (CLIP_EN && (in_y1 > LIM_Y)) ? LIM_Y : in_y1;
  end

  abs_diff #(.WIDTH(WIDTH)) u_abs_dx (.a(x0_reg), .b(x1_reg), .y(adx));
  abs_diff #(.WIDTH(WIDTH)) u_abs_dy (.a(y0_reg), .b(y1_reg), .y(ady));

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: fixed three-step setup, then hold until the drawer finishes
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (in_valid) state_next = ST_DIFF;
      ST_DIFF:    state_next = ST_SWAPXY;
      ST_SWAPXY:  state_next = ST_ORDER;
      ST_ORDER:   state_next = ST_START;
      ST_START:   if (draw_done) state_next = ST_RELEASE;
      ST_RELEASE: if (!draw_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture, difference, octant swap, endpoint ordering, stt hold
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x0_reg         <= '0;
      y0_reg         <= '0;
      x1_reg         <= '0;
      y1_reg         <= '0;
      color_reg      <= '0;
      adx_reg        <= '0;
      ady_reg        <= '0;
      steep_work_reg <= 1'b0;
      realx0_reg     <= '0;
      realy0_reg     <= '0;
      realx1_reg     <= '0;
      realy1_reg     <= '0;
      color_out_reg  <= '0;
      steep_reg      <= 1'b0;
      stt_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x0_reg    <= cap_x0;
            y0_reg    <= cap_y0;
            x1_reg    <= cap_x1;
            y1_reg    <= cap_y1;
            color_reg <= in_color;
          end
        end
        ST_DIFF: begin
          adx_reg <= adx;
          ady_reg <= ady;
        end
        ST_SWAPXY: begin
          // strict compare: 45-degree lines stay non-steep
          steep_work_reg <= (ady_reg > adx_reg);
          if (ady_reg > adx_reg) begin
            x0_reg <= y0_reg;
            y0_reg <= x0_reg;
            x1_reg <= y1_reg;
            y1_reg <= x1_reg;
          end
        end
        ST_ORDER: begin
          if (x0_reg > x1_reg) begin
            realx0_reg <= x1_reg;
            realy0_reg <= y1_reg;
            realx1_reg <= x0_reg;
            realy1_reg <= y0_reg;
          end else begin
            realx0_reg <= x0_reg;
            realy0_reg <= y0_reg;
            realx1_reg <= x1_reg;
            realy1_reg <= y1_reg;
          end
          steep_reg     <= steep_work_reg;
          color_out_reg <= color_reg;
        end
        default: ;
      endcase
      // stt rises the edge after START is entered and drops the edge after draw_done
      stt_reg <= (state_reg == ST_START) && !draw_done;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign stt       = stt_reg;
  assign steep     = steep_reg;
  assign realx0    = realx0_reg;
  assign realy0    = realy0_reg;
  assign realx1    = realx1_reg;
  assign realy1    = realy1_reg;
  assign color_out = color_out_reg;

endmodule

// File: tb/tb_line_setup.sv
// Directed bench for line_setup: reset state, normalisation cases,
// handshake timing, optional clipping and asynchronous reset mid-draw.
module tb_line_setup;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_x0, in_y0, in_x1, in_y1;
  logic [2:0] in_color;
  logic       draw_done;
  logic       stt, steep, busy;
  logic [8:0] realx0, realy0, realx1, realy1;
  logic [2:0] color_out;

  int vectors     = 0;
  int miscompares = 0;

  line_setup dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x0    (in_x0),
    .in_y0    (in_y0),
    .in_x1    (in_x1),
    .in_y1    (in_y1),
    .in_color (in_color),
    .draw_done(draw_done),
    .stt      (stt),
    .steep    (steep),
    .realx0   (realx0),
    .realy0   (realy0),
    .realx1   (realx1),
    .realy1   (realy1),
    .color_out(color_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1 time unit
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int ex0, input int ey0, input int ex1,
                         input int ey1, input int est, input int ecol);
    chk({tag, ".realx0"}, 32'(realx0), ex0);
    chk({tag, ".realy0"}, 32'(realy0), ey0);
    chk({tag, ".realx1"}, 32'(realx1), ex1);
    chk({tag, ".realy1"}, 32'(realy1), ey1);
    chk({tag, ".steep"},  32'(steep),  est);
    chk({tag, ".color"},  32'(color_out), ecol);
  endtask

  // Present a request for one edge and walk it up to the stt rise (edge E+4)
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int col);
    in_x0 = 9'(x0); in_y0 = 9'(y0); in_x1 = 9'(x1); in_y1 = 9'(y1);
    in_color = 3'(col);
    in_valid = 1'b1;
    step();                         // edge E: accepted
    in_valid = 1'b0;
    chk("in_ready_low_after_accept", 32'(in_ready), 0);
    chk("busy_after_accept", 32'(busy), 1);
    step(); step(); step();         // edges E+1..E+3
    chk("stt_low_at_E3", 32'(stt), 0);
    step();                         // edge E+4
    chk("stt_high_at_E4", 32'(stt), 1);
  endtask

  // One-cycle draw: stt falls one edge after draw_done, in_ready returns after it drops
  task automatic finish_draw();
    draw_done = 1'b1;
    step();
    chk("stt_fall", 32'(stt), 0);
    draw_done = 1'b0;
    step();
    chk("in_ready_return", 32'(in_ready), 1);
  endtask

  task automatic line(input string tag, input int x0, input int y0, input int x1, input int y1,
                      input int col, input int ex0, input int ey0, input int ex1, input int ey1,
                      input int est);
    issue(x0, y0, x1, y1, col);
    chk_out(tag, ex0, ey0, ex1, ey1, est, col);
    finish_draw();
    $display("line %s (%0d,%0d)->(%0d,%0d) -> %0d/%0d/%0d/%0d steep=%0d", tag, x0, y0, x1, y1,
             realx0, realy0, realx1, realy1, steep);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; draw_done = 1'b0;
    in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0; in_color = '0;
    step(); step();
    chk("reset.in_ready", 32'(in_ready), 1);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.stt", 32'(stt), 0);
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    line("shallow", 10, 20, 50, 30, 5, 10, 20, 50, 30, 0);
    line("steep",   30, 100, 20, 10, 3, 10, 20, 100, 30, 1);
    line("diag",    5, 5, 0, 0, 6, 0, 0, 5, 5, 0);
    line("point",   7, 7, 7, 7, 1, 7, 7, 7, 7, 0);

    // handshake: in_valid while busy is ignored; 3-cycle draw_done pulse
    in_x0 = 9'd1; in_y0 = 9'd2; in_x1 = 9'd3; in_y1 = 9'd4; in_color = 3'd2;
    in_valid = 1'b1;
    step();
    in_x0 = 9'd200; in_y0 = 9'd100; in_x1 = 9'd9; in_y1 = 9'd8; in_color = 3'd7;
    step();
    chk("hs.busy_ignores_valid", 32'(busy), 1);
    step(); step(); step();         // E+4, in_valid still high
    in_valid = 1'b0;
    chk("hs.stt_high", 32'(stt), 1);
    chk_out("hs", 1, 2, 3, 4, 0, 2);
    draw_done = 1'b1;
    step();
    chk("hs.stt_fall_one_edge", 32'(stt), 0);
    step();
    chk("hs.still_busy", 32'(busy), 1);
    step();
    chk("hs.in_ready_held_low", 32'(in_ready), 0);
    draw_done = 1'b0;
    step();
    chk("hs.in_ready_return", 32'(in_ready), 1);
    chk_out("hs.hold_idle", 1, 2, 3, 4, 0, 2);
    $display("handshake done busy=%0d in_ready=%0d", busy, in_ready);

`ifdef LINE_SETUP_CLIP_EN
    line("clip", 400, 300, 0, 0, 4, 0, 0, 319, 239, 0);
`else
    line("noclip", 400, 300, 0, 0, 4, 0, 0, 400, 300, 0);
`endif

    // asynchronous reset while stt is held
    issue(10, 20, 50, 30, 5);
    #1 rst = 1'b1;
    #1;
    chk("async_reset.stt", 32'(stt), 0);
    step();
    chk("async_reset.in_ready", 32'(in_ready), 1);
    chk("async_reset.busy", 32'(busy), 0);
    chk_out("async_reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    $display("async reset stt=%0d in_ready=%0d", stt, in_ready);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_setup.md
# line_setup

Upstream stage of the Bresenham line drawer. Accepts one raw line request (two endpoints plus colour) over a valid/ready handshake and normalises it into the form the drawer expects: the line is made shallow by an x/y swap with `steep` flagged, and the endpoints are ordered so that `realx0 <= realx1`. It then raises `stt`, holds it for the whole draw, and releases it on `draw_done`, giving the drawer's waiting→idle exit a clean return-to-zero.

## Interface
Parameters:
- `WIDTH`, 9: coordinate width (unsigned).
- `MAX_X`, 319: largest visible x.
- `MAX_Y`, 239: largest visible y.

Ports:
- `CLOCK_50`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  high only in IDLE.
- `in_x0`, `in_y0`, `in_x1`, `in_y1`  in  WIDTH each  raw endpoints.
- `in_color`  in  3  pixel colour.
- `draw_done`  in  1  level signal from the drawer: line finished; stays high until `stt` falls.
- `stt`  out  1  start/hold to the drawer.
- `steep`  out  1  x/y swapped; the drawer swaps x and y back when plotting.
- `realx0`, `realy0`, `realx1`, `realy1`  out  WIDTH each  normalised endpoints.
- `color_out`  out  3  latched colour for the VGA path.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DIFF, SWAPXY, ORDER, START, RELEASE.
- **IDLE:** `in_ready=1`. When `in_valid` is high, capture all inputs into working registers, then go to DIFF.
- **DIFF:** register `adx=|x0-x1|` and `ady=|y0-y1|`, each computed as max−min in WIDTH unsigned bits (no overflow possible). Go to SWAPXY.
- **SWAPXY:** set `steep = (ady > adx)`. The comparison is strict, so equal magnitudes give `steep=0`. If steep, swap x↔y within each endpoint. Go to ORDER.
- **ORDER:** if `x0 > x1` (unsigned), exchange the two endpoints as whole pairs. Write the results to `realx0`..`realy1`. Go to START.
- **START:** `stt=1`. Stay until `draw_done=1`, then go to RELEASE.
- **RELEASE:** `stt=0`. Stay until `draw_done=0`; minimum one cycle. Then go to IDLE.
- Degenerate input (`x0==x1` and `y0==y1`) is still issued as a one-pixel line.
- `realx0`..`realy1`, `steep` and `color_out` change only in ORDER. They hold their values through IDLE until the next request reaches ORDER.
- `in_valid` outside IDLE is ignored; requests are not queued.
- **Reset:** state goes to IDLE immediately. All outputs are 0 except `in_ready`, which is 1.
- **Reset mid-operation** (any state): `stt` drops asynchronously and the request is discarded. The top level must reset the drawer at the same time.

## Timing
- Acceptance happens on edge E (`in_valid & in_ready`). Then:
  - DIFF runs in cycle E+1.
  - SWAPXY runs in E+2.
  - ORDER runs in E+3.
  - `stt` rises after edge E+4.
  - Normalised outputs are valid from the same edge and stay stable while `stt=1`.
- `in_ready` falls on the cycle after acceptance.
- After `draw_done` rises, `stt` falls on the next edge.
- If `draw_done` is already low on RELEASE entry, `in_ready` returns one edge later. Minimum request-to-request spacing is therefore 7 cycles plus the draw time.
- `draw_done` high while in IDLE or DIFF..ORDER is ignored.

## Configuration
- `LINE_SETUP_CLIP_EN` defined: at capture, any x > `MAX_X` is clamped to `MAX_X` and any y > `MAX_Y` is clamped to `MAX_Y`, before DIFF.
- Not defined: coordinates pass through unclamped; the full WIDTH range is used.

## Structure
- Package `line_pkg`:
  - state enum `line_setup_state_t`;
  - `COORD_W=9`;
  - `SCREEN_MAX_X=319`, `SCREEN_MAX_Y=239`;
  - colour width 3.
- Sub-module `abs_diff` (combinational, WIDTH-parameterised): outputs `|a-b|`. Instantiated twice in DIFF.

## Test plan
- Reset asserted mid-START → `stt=0` immediately. Next cycle: `in_ready=1`, `busy=0`, all normalised outputs 0.
- (10,20)→(50,30) → `steep=0`; realx0/y0/x1/y1 = 10/20/50/30; `stt` high 4 edges after acceptance.
- (30,100)→(20,10) → `steep=1`; outputs 10/20/100/30.
- (5,5)→(0,0) with equal slopes → `steep=0`; outputs 0/0/5/5. Also (7,7)→(7,7) → single-pixel request, `stt` still raised.
- Handshake sequence:
  - A second `in_valid` while `busy=1` is ignored.
  - `draw_done` pulsed high for 3 cycles → `stt` falls one edge after the rise.
  - `in_ready` returns one edge after `draw_done` falls.
- (400,300)→(0,0):
  - With `LINE_SETUP_CLIP_EN` → outputs 0/0/319/239, `steep=0`.
  - Without it → outputs 0/0/400/300, `steep=0`.
